// File: rtl/dmu_siu_ib_pkg.sv
// Shared types and helpers for the DMU->SII inbound protocol checker.
//   pkt_class_e : packet class reported on pkt_class / used to pick a counter
//   state_e     : header/payload tracking FSM states
//   ERR_*       : bit positions inside err_pulse / err_sticky
//   lane_parity : expected parity bit for one 16-bit lane
package dmu_siu_ib_pkg;

    typedef enum logic [1:0] {
        CLS_RD    = 2'd0,
        CLS_WR    = 2'd1,
        CLS_MONDO = 2'd2,
        CLS_PIO   = 2'd3
    } pkt_class_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_PAY = 2'd1,
        ST_MD_PAY = 2'd2
    } state_e;

    localparam int ERR_W           = 5;
    localparam int ERR_ILLEGAL_ENC = 0;
    localparam int ERR_HDR_IN_PAY  = 1;
    localparam int ERR_PARITY      = 2;
    localparam int ERR_OVERFLOW    = 3;
    localparam int ERR_UNDERFLOW   = 4;

    // Even parity when odd=0; odd parity flips the expected bit.
    function automatic logic lane_parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/dmu_siu_ib_credit_ctr.sv
// Bounded up/down counter used to track outstanding DMA write credits.
//   clk, reset       : clock, synchronous active-high reset
//   en               : 0 freezes the count and suppresses both flags
//   inc, dec         : count request / release; both together cancel
//   count            : current count, 0..MAX
//   overflow         : combinational, inc refused because count == MAX
//   underflow        : combinational, dec refused because count == 0
module dmu_siu_ib_credit_ctr #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow,
    output logic         underflow
);

    // A simultaneous inc/dec is a net no-op, so it never trips a bound.
    always_comb begin
        overflow  = en && inc && !dec && (count == W'(MAX));
        underflow = en && dec && !inc && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && !overflow && !underflow) begin
            if (inc && !dec)
                count <= count + W'(1);
            else if (dec && !inc)
                count <= count - W'(1);
        end
    end

endmodule

// File: rtl/dmu_siu_ib_checker.sv
// Inbound DMU->SII protocol checker. Decodes header cycles, walks payload
// beats, checks lane parity and write-credit balance, counts packets.
//   iol2clk, reset        : clock, synchronous active-high reset
//   en                    : 0 freezes all state; pulses forced to 0
//   dmu_sii_*             : tapped inbound header/payload interface
//   sii_dmu_wrack_*       : write ack (credit return) and its tag
//   rd/wr/mondo/pio_cnt   : saturating completed-packet counters
//   wr_outstanding        : unacked DMA writes
//   pkt_done, pkt_class   : completion pulse and its class
//   err_pulse, err_sticky : {underflow, overflow, parity, hdr_in_payload, illegal_enc}
//   last_wrack_tag        : tag of the most recent wrack
module dmu_siu_ib_checker
    import dmu_siu_ib_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter int PAR_W          = DATA_W / 16,
    parameter int WR_BEATS       = 4,
    parameter int MONDO_BEATS    = 1,
    parameter int MAX_WR_CREDITS = 16,
    parameter int CNT_W          = 16,
    parameter int PARITY_ODD     = 0
) (
    input  logic                                  iol2clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic                                  dmu_sii_hdr_vld,
    input  logic                                  dmu_sii_reqbypass,
    input  logic                                  dmu_sii_datareq,
    input  logic                                  dmu_sii_datareq16,
    input  logic [DATA_W-1:0]                     dmu_sii_data,
    input  logic [PAR_W-1:0]                      dmu_sii_parity,
    input  logic                                  sii_dmu_wrack_vld,
    input  logic [3:0]                            sii_dmu_wrack_tag,
    output logic [CNT_W-1:0]                      rd_cnt,
    output logic [CNT_W-1:0]                      wr_cnt,
    output logic [CNT_W-1:0]                      mondo_cnt,
    output logic [CNT_W-1:0]                      pio_cnt,
    output logic [$clog2(MAX_WR_CREDITS+1)-1:0]   wr_outstanding,
    output logic                                  pkt_done,
    output logic [1:0]                            pkt_class,
    output logic [ERR_W-1:0]                      err_pulse,
    output logic [ERR_W-1:0]                      err_sticky,
    output logic [3:0]                            last_wrack_tag
);

    localparam int MAX_BEATS = (WR_BEATS > MONDO_BEATS) ? WR_BEATS : MONDO_BEATS;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    state_e              state, state_nx;
    pkt_class_e          cls_lat, cls_nx;
    logic [BEAT_W-1:0]   beat, beat_nx, last_beat;
    logic                in_pay;
    logic                done_nx;
    logic [1:0]          done_cls_nx;
    logic [ERR_W-1:0]    err_nx;
    logic                wr_hdr;
    logic                cred_ovf, cred_unf;
    logic [PAR_W-1:0]    lane_bad;

    // Per-lane parity mismatch against the expected even/odd parity.
    for (genvar i = 0; i < PAR_W; i++) begin : g_lane
        assign lane_bad[i] = dmu_sii_parity[i]
                           ^ lane_parity(dmu_sii_data[16*i +: 16], PARITY_ODD != 0);
    end

    assign in_pay    = (state != ST_IDLE);
    assign last_beat = (state == ST_WR_PAY) ? BEAT_W'(WR_BEATS - 1)
                                            : BEAT_W'(MONDO_BEATS - 1);

    always_comb begin
        state_nx    = state;
        beat_nx     = beat;
        cls_nx      = cls_lat;
        done_nx     = 1'b0;
        done_cls_nx = pkt_class;
        err_nx      = '0;
        wr_hdr      = 1'b0;
        if (en) begin
            if (dmu_sii_hdr_vld) begin
                // A header always wins: any packet in flight is dropped
                // uncounted and the new header is decoded in its place.
                err_nx[ERR_HDR_IN_PAY] = in_pay;
                beat_nx = '0;
                case ({dmu_sii_datareq, dmu_sii_datareq16})
                    2'b00: begin
                        done_nx     = 1'b1;
                        done_cls_nx = CLS_RD;
                        state_nx    = ST_IDLE;
                    end
                    2'b10: begin
                        state_nx = ST_WR_PAY;
                        cls_nx   = CLS_WR;
                        wr_hdr   = 1'b1;
                    end
                    2'b11: begin
                        state_nx = ST_MD_PAY;
                        cls_nx   = dmu_sii_reqbypass ? CLS_PIO : CLS_MONDO;
                    end
                    default: begin
                        state_nx = ST_IDLE;
                        err_nx[ERR_ILLEGAL_ENC] = 1'b1;
                    end
                endcase
            end else if (in_pay) begin
                // Payload has no valid strobe: every cycle in a payload
                // state is one beat.
                if (beat == last_beat) begin
                    done_nx     = 1'b1;
                    done_cls_nx = cls_lat;
                    state_nx    = ST_IDLE;
                    beat_nx     = '0;
                end else begin
                    beat_nx = beat + BEAT_W'(1);
                end
            end
            err_nx[ERR_PARITY]    = (dmu_sii_hdr_vld || in_pay) && (|lane_bad);
            err_nx[ERR_OVERFLOW]  = cred_ovf;
            err_nx[ERR_UNDERFLOW] = cred_unf;
        end
    end

    dmu_siu_ib_credit_ctr #(
        .MAX (MAX_WR_CREDITS),
        .W   ($clog2(MAX_WR_CREDITS + 1))
    ) u_credit (
        .clk       (iol2clk),
        .reset     (reset),
        .en        (en),
        .inc       (wr_hdr),
        .dec       (sii_dmu_wrack_vld),
        .count     (wr_outstanding),
        .overflow  (cred_ovf),
        .underflow (cred_unf)
    );

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            beat           <= '0;
            cls_lat        <= CLS_RD;
            pkt_done       <= 1'b0;
            pkt_class      <= '0;
            err_pulse      <= '0;
            err_sticky     <= '0;
            last_wrack_tag <= '0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            mondo_cnt      <= '0;
            pio_cnt        <= '0;
        end else begin
            state      <= state_nx;
            beat       <= beat_nx;
            cls_lat    <= cls_nx;
            pkt_done   <= done_nx;
            pkt_class  <= done_cls_nx;
            err_pulse  <= err_nx;
            err_sticky <= err_sticky | err_nx;
            if (en && sii_dmu_wrack_vld)
                last_wrack_tag <= sii_dmu_wrack_tag;
            if (done_nx) begin
                case (done_cls_nx)
                    CLS_RD:    if (rd_cnt    != '1) rd_cnt    <= rd_cnt    + CNT_W'(1);
                    CLS_WR:    if (wr_cnt    != '1) wr_cnt    <= wr_cnt    + CNT_W'(1);
                    CLS_MONDO: if (mondo_cnt != '1) mondo_cnt <= mondo_cnt + CNT_W'(1);
                    default:   if (pio_cnt   != '1) pio_cnt   <= pio_cnt   + CNT_W'(1);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmu_siu_ib_checker.sv
// Directed bench for dmu_siu_ib_checker: a per-cycle vector table followed
// by hand-written sequences for credit bounds, reset mid-packet and counter
// saturation. Counters are narrowed to 4 bits so saturation is reachable.
module tb_dmu_siu_ib_checker;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset, en, hdr_vld, reqbypass, datareq, datareq16;
    logic [127:0] data;
    logic [7:0]  parity;
    logic        wrack_vld;
    logic [3:0]  wrack_tag;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, mondo_cnt, pio_cnt;
    logic [4:0]  wr_outstanding;
    logic        pkt_done;
    logic [1:0]  pkt_class;
    logic [4:0]  err_pulse, err_sticky;
    logic [3:0]  last_wrack_tag;

    always #5 clk = ~clk;

    dmu_siu_ib_checker #(.CNT_W(CNT_W)) dut (
        .iol2clk           (clk),
        .reset             (reset),
        .en                (en),
        .dmu_sii_hdr_vld   (hdr_vld),
        .dmu_sii_reqbypass (reqbypass),
        .dmu_sii_datareq   (datareq),
        .dmu_sii_datareq16 (datareq16),
        .dmu_sii_data      (data),
        .dmu_sii_parity    (parity),
        .sii_dmu_wrack_vld (wrack_vld),
        .sii_dmu_wrack_tag (wrack_tag),
        .rd_cnt            (rd_cnt),
        .wr_cnt            (wr_cnt),
        .mondo_cnt         (mondo_cnt),
        .pio_cnt           (pio_cnt),
        .wr_outstanding    (wr_outstanding),
        .pkt_done          (pkt_done),
        .pkt_class         (pkt_class),
        .err_pulse         (err_pulse),
        .err_sticky        (err_sticky),
        .last_wrack_tag    (last_wrack_tag)
    );

    typedef struct {
        logic        rst, en, hv, byp, dr, dr16;
        logic [31:0] d;
        logic [7:0]  p;
        logic        wv;
        logic [3:0]  tag;
        logic        done;
        logic [1:0]  cls;
        logic [4:0]  err, stk, wro;
        logic [3:0]  rd, wr, md, pio, lt;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t V(
        input logic rst, en, hv, byp, dr, dr16,
        input logic [31:0] d, input logic [7:0] p, input logic wv, input logic [3:0] tag,
        input logic done, input logic [1:0] cls, input logic [4:0] err, stk, wro,
        input logic [3:0] rd, wr, md, pio, lt);
        vec_t v;
        v.rst = rst; v.en = en; v.hv = hv; v.byp = byp; v.dr = dr; v.dr16 = dr16;
        v.d = d; v.p = p; v.wv = wv; v.tag = tag;
        v.done = done; v.cls = cls; v.err = err; v.stk = stk; v.wro = wro;
        v.rd = rd; v.wr = wr; v.md = md; v.pio = pio; v.lt = lt;
        return v;
    endfunction

    task automatic drive(input logic rst, en_i, hv, byp, dr, dr16,
                         input logic [31:0] d, input logic [7:0] p,
                         input logic wv, input logic [3:0] tag);
        reset = rst; en = en_i; hdr_vld = hv; reqbypass = byp;
        datareq = dr; datareq16 = dr16; data = {96'b0, d}; parity = p;
        wrack_vld = wv; wrack_tag = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        //      rst en hv byp dr d16 data  par wv tag | done cls err       stk       wro rd wr md pio lt
        tv.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0));   // 0 reset
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0));   // 1 idle
        tv.push_back(V(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0, 0));   // 2 read
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0, 0));   // 3
        tv.push_back(V(0, 1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0));   // 4 write hdr T
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0));   // 5 beat 1
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0));   // 6 beat 2
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0));   // 7 beat 3
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 5'b00000, 5'b00000, 1, 1, 1, 0, 0, 0));   // 8 beat 4 -> done T+5
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 1, 0, 0, 0));   // 9
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 1, 0, 0, 0));   // 10
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 1, 0, 0, 0));   // 11
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0, 0, 5));   // 12 wrack T+8
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0, 0, 5));   // 13
        tv.push_back(V(0, 1, 1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0, 0, 5));   // 14 mondo hdr
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2, 5'b00000, 5'b00000, 0, 1, 1, 1, 0, 5));   // 15 beat -> mondo done
        tv.push_back(V(0, 1, 1, 1, 1, 1, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 1, 1, 1, 0, 5));   // 16 PIO hdr back-to-back
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 5'b00000, 5'b00000, 0, 1, 1, 1, 1, 5));   // 17 beat -> PIO done
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 0, 1, 1, 1, 1, 5));   // 18
        tv.push_back(V(0, 1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 1, 5));   // 19 write hdr
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 1, 5));   // 20 beat 1
        tv.push_back(V(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 5'b00010, 5'b00010, 1, 2, 1, 1, 1, 5));   // 21 read at beat 2
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00010, 1, 2, 1, 1, 1, 5));   // 22 write abandoned
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00010, 1, 2, 1, 1, 1, 5));   // 23
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00010, 1, 2, 1, 1, 1, 5));   // 24
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00010, 1, 2, 1, 1, 1, 5));   // 25
        tv.push_back(V(0, 1, 1, 0, 0, 0, 0, 8'h08, 0, 0, 1, 0, 5'b00100, 5'b00110, 1, 3, 1, 1, 1, 5)); // 26 lane 3 parity bad
        tv.push_back(V(0, 1, 1, 0, 0, 0, 32'h1, 8'h01, 0, 0, 1, 0, 5'b00000, 5'b00110, 1, 4, 1, 1, 1, 5)); // 27 lane 0 parity good
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00110, 1, 4, 1, 1, 1, 5));   // 28
        tv.push_back(V(0, 1, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 5'b00001, 5'b00111, 1, 4, 1, 1, 1, 5));   // 29 illegal enc
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b00111, 1, 4, 1, 1, 1, 5));   // 30 still idle
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0, 0, 5'b00000, 5'b00111, 0, 4, 1, 1, 1, 4'hA)); // 31 wrack 1->0
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 5'b10000, 5'b10111, 0, 4, 1, 1, 1, 3));   // 32 underflow
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 3));   // 33
        tv.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 1, 4'hF, 0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 3));  // 34 en=0 ignores all
        tv.push_back(V(0, 1, 1, 0, 1, 0, 0, 0, 1, 7,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 7));   // 35 write hdr + wrack
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 7));   // 36 beat 1
        tv.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 7));   // 37 frozen
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 7));   // 38 beat 2
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 1, 1, 1, 7));   // 39 beat 3
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 5'b00000, 5'b10111, 0, 4, 2, 1, 1, 7));   // 40 beat 4 -> done
        tv.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5'b00000, 5'b10111, 0, 4, 2, 1, 1, 7));   // 41

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].hv, tv[i].byp, tv[i].dr, tv[i].dr16,
                  tv[i].d, tv[i].p, tv[i].wv, tv[i].tag);
            step();
            chk("pkt_done", i, pkt_done, tv[i].done);
            if (tv[i].done || tv[i].rst)
                chk("pkt_class", i, pkt_class, tv[i].cls);
            chk("err_pulse", i, err_pulse, tv[i].err);
            chk("err_sticky", i, err_sticky, tv[i].stk);
            chk("wr_outstanding", i, wr_outstanding, tv[i].wro);
            chk("rd_cnt", i, rd_cnt, tv[i].rd);
            chk("wr_cnt", i, wr_cnt, tv[i].wr);
            chk("mondo_cnt", i, mondo_cnt, tv[i].md);
            chk("pio_cnt", i, pio_cnt, tv[i].pio);
            chk("last_wrack_tag", i, last_wrack_tag, tv[i].lt);
        end

        // Credit overflow: 17 back-to-back write headers, no acks.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
            step();
            chk("ovf_wro", k, wr_outstanding, (k > 16) ? 16 : k);
            chk("ovf_err", k, err_pulse[3], k == 17);
        end

        // Reset in the middle of write payload.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_done", 0, pkt_done, 0);
        chk("rst_class", 0, pkt_class, 0);
        chk("rst_err", 0, err_pulse, 0);
        chk("rst_sticky", 0, err_sticky, 0);
        chk("rst_wro", 0, wr_outstanding, 0);
        chk("rst_cnts", 0, {rd_cnt, wr_cnt, mondo_cnt, pio_cnt}, 0);
        chk("rst_tag", 0, last_wrack_tag, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_no_done", k, pkt_done, 0);
            chk("rst_wr_cnt", k, wr_cnt, 0);
        end

        // Underflow straight after reset.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 9);
        step();
        chk("unf_err", 0, err_pulse, 5'b10000);
        chk("unf_wro", 0, wr_outstanding, 0);
        chk("unf_tag", 0, last_wrack_tag, 9);

        // Counter saturation at all-ones.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
            chk("sat_done", k, pkt_done, 1);
            chk("sat_rd_cnt", k, rd_cnt, (k > 15) ? 15 : k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmu_siu_ib_checker.md
# dmu_siu_ib_checker

Synthesizable, parametrised inbound-path protocol checker for the DMU→SII interface. Decodes every header cycle and tracks payload beats through a small FSM. Checks per-lane parity and DMA write-credit balance against SII write acks. Exports saturating per-class packet counters plus sticky and pulsed error flags. Taps the same `SII` boundary signals as the inbound monitors; usable in simulation and emulation.

## Interface
- DATA_W, 128, payload/header width; multiple of 16
- PAR_W, DATA_W/16, parity bits, one per 16-bit lane
- WR_BEATS, 4, payload beats following a DMA write header
- MONDO_BEATS, 1, payload beats following a mondo/PIO-read-return header
- MAX_WR_CREDITS, 16, maximum outstanding unacked DMA writes
- CNT_W, 16, width of each packet counter
- PARITY_ODD, 0, 0 = even parity per lane, 1 = odd

Ports:
- iol2clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  checker enable; 0 freezes FSM, counters, and credit count
- dmu_sii_hdr_vld  in  1  header cycle valid
- dmu_sii_reqbypass  in  1  bypass queue select
- dmu_sii_datareq  in  1  payload follows
- dmu_sii_datareq16  in  1  16-byte payload class
- dmu_sii_data  in  DATA_W  header/payload bus
- dmu_sii_parity  in  PAR_W  lane parity
- sii_dmu_wrack_vld  in  1  write ack / credit return
- sii_dmu_wrack_tag  in  4  ack tag; captured only
- rd_cnt, wr_cnt, mondo_cnt, pio_cnt  out  CNT_W each  completed packets per class; saturating
- wr_outstanding  out  $clog2(MAX_WR_CREDITS+1)  unacked write count
- pkt_done  out  1  one-cycle pulse when a packet completes
- pkt_class  out  2  0 read, 1 write, 2 mondo, 3 PIO return; valid with pkt_done
- err_pulse  out  5  per-cycle error: {underflow, overflow, parity, hdr_in_payload, illegal_enc}
- err_sticky  out  5  OR-accumulated err_pulse; cleared only by reset
- last_wrack_tag  out  4  tag of the most recent wrack

## Operation
- Header decode on hdr_vld, by {datareq, datareq16}:
  - 00: DMA read; completes on the header cycle
  - 10: DMA write; enter WR_PAY for WR_BEATS beats
  - 11 with reqbypass=0: mondo; 11 with reqbypass=1: PIO read return. Class is latched at the header. Enter MD_PAY for MONDO_BEATS beats.
  - 01: illegal_enc; no packet is counted; FSM stays IDLE.
- FSM states: IDLE, WR_PAY, MD_PAY. A beat counter counts every cycle while in a payload state; at the last beat the FSM returns to IDLE.
- A header during WR_PAY/MD_PAY raises hdr_in_payload. The current packet is abandoned, not counted, and the new header is decoded normally that same cycle.
- Parity is checked on every header and payload cycle. Lane i expects parity[i] = ^data[16i+15:16i] ^ PARITY_ODD. Any lane mismatch raises the parity error for that cycle. The packet is still counted.
- Credits:
  - A write header increments wr_outstanding. wrack_vld decrements it. Both in the same cycle leave it unchanged.
  - An increment at MAX_WR_CREDITS raises overflow; the count holds.
  - A decrement at 0 raises underflow; the count holds at 0.
  - wrack is processed in any FSM state.
- Counters saturate at all-ones.
- en=0: all state holds, no errors raised, pulses are 0.

## Timing
- All outputs are registered. Reset values: all counters 0, wr_outstanding 0, pkt_done 0, pkt_class 0, err_pulse 0, err_sticky 0, last_wrack_tag 0, FSM IDLE.
- Read: pkt_done asserts the cycle after the header (latency 1).
- Write: header at cycle T, payload beats T+1..T+WR_BEATS, pkt_done at T+WR_BEATS+1. Mondo/PIO follow the same pattern with MONDO_BEATS.
- A back-to-back header on the cycle after the last beat is legal and produces no error.
- The counter increments in the same cycle pkt_done is high.
- err_pulse is asserted the cycle after the offending input. err_sticky updates in that same cycle.
- wr_outstanding reflects the header/wrack activity of the previous cycle.
- Reset asserted mid-packet: the next cycle is IDLE, no pkt_done, and the partial packet is dropped.

## Structure
- Package dmu_siu_ib_pkg holds: the pkt_class enum (RD, WR, MONDO, PIO), the FSM state enum, the err bit index constants, and the function lane_parity(data, odd).
- One sub-module, dmu_siu_ib_credit_ctr. It implements the saturating up/down counter with overflow/underflow flags and is reused for credit tracking.

## Test plan
- Read header, data=0, parity=0 → rd_cnt=1, pkt_done at T+1 with class 0, no errors.
- Write header plus 4 beats, then wrack_vld with tag 0x5 at T+8 → wr_cnt=1, pkt_done at T+5; wr_outstanding goes 1 then 0; last_wrack_tag=0x5.
- Mondo header (11, bypass 0) then PIO header (11, bypass 1) back-to-back → mondo_cnt=1, pio_cnt=1, pkt_class 2 then 3, no hdr_in_payload.
- Write header, then a new read header at beat 2 → err_pulse[1] for 1 cycle, wr_cnt=0, rd_cnt=1, err_sticky[1]=1.
- Header with lane 3 parity flipped → err_pulse[2]=1 at T+1; packet still counted.
- 17 write headers with no wracks → overflow on the 17th, wr_outstanding=16. A wrack at 0 outstanding after reset → underflow. Reset asserted mid-WR_PAY → all outputs 0 next cycle.
